// File: rtl/slc3_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : slc3_stim_sequencer
// Purpose  : Script-driven stimulus sequencer for the SLC-3 front panel.
//            Plays back a loadable script of SET_SW / PULSE_RUN / PULSE_CONT /
//            END entries with cycle-exact per-entry post-delays. Supports
//            one-shot or looping playback, abort and status reporting.
// Ports    : Clk, Reset          - clock, synchronous active-high reset
//            wr_en/wr_addr/wr_data - script write port (rejected while busy)
//            start/abort/loop_en - playback control
//            SW, Run, Continue   - panel outputs (buttons active-low)
//            busy, done, pc      - playback status
//            wr_err              - one-cycle pulse on a rejected write
// Revision : 1.0 - initial release
// ============================================================================
module slc3_stim_sequencer #(
    parameter int SW_WIDTH    = 10,
    parameter int DEPTH       = 16,
    parameter int DELAY_WIDTH = 16,
    parameter int PULSE_LEN   = 2,
    parameter int AW          = $clog2(DEPTH),
    parameter int EW          = 2 + SW_WIDTH + DELAY_WIDTH
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [EW-1:0]       wr_data,
    input  logic                start,
    input  logic                abort,
    input  logic                loop_en,
    output logic [SW_WIDTH-1:0] SW,
    output logic                Run,
    output logic                Continue,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       pc,
    output logic                wr_err
);

    // The counter must hold both a full delay and PULSE_LEN-1.
    localparam int PL_W  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int CNT_W = (DELAY_WIDTH > PL_W) ? DELAY_WIDTH : PL_W;

    localparam logic [1:0] c_OP_SET_SW     = 2'b00;
    localparam logic [1:0] c_OP_PULSE_RUN  = 2'b01;
    localparam logic [1:0] c_OP_PULSE_CONT = 2'b10;

    localparam logic [CNT_W-1:0] c_PULSE_CNT = CNT_W'(PULSE_LEN - 1);
    localparam logic [AW-1:0]    c_LAST_PC   = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [SW_WIDTH-1:0]   sw_q, sw_d;
    logic                  run_q, run_d;
    logic                  cont_q, cont_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [AW-1:0]         pc_q, pc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_err_q;

    logic [EW-1:0]         mem_q [DEPTH];

    logic [EW-1:0]          w_entry;
    logic [1:0]             w_op;
    logic [SW_WIDTH-1:0]    w_value;
    logic [DELAY_WIDTH-1:0] w_delay;

    assign w_entry = mem_q[pc_q];
    assign w_op    = w_entry[EW-1 -: 2];
    assign w_value = w_entry[EW-3 -: SW_WIDTH];
    assign w_delay = w_entry[DELAY_WIDTH-1:0];

    // Script memory: deliberately not reset so a script survives Reset.
    always_ff @(posedge Clk) begin
        if (wr_en && !busy_q) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        run_d   = run_q;
        cont_d  = cont_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        if (abort) begin
            // Abort beats every transition; SW and done are left as-is.
            state_d = S_IDLE;
            run_d   = 1'b1;
            cont_d  = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_d    = '0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        c_OP_SET_SW: begin
                            sw_d    = w_value;
                            cnt_d   = CNT_W'(w_delay);
                            state_d = S_WAIT;
                        end
                        c_OP_PULSE_RUN: begin
                            run_d   = 1'b0;
                            cnt_d   = c_PULSE_CNT;
                            state_d = S_PULSE;
                        end
                        c_OP_PULSE_CONT: begin
                            cont_d  = 1'b0;
                            cnt_d   = c_PULSE_CNT;
                            state_d = S_PULSE;
                        end
                        default: begin
                            // END: loop costs one EXEC bubble at pc 0.
                            if (loop_en) begin
                                pc_d = '0;
                            end else begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    endcase
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        run_d   = 1'b1;
                        cont_d  = 1'b1;
                        cnt_d   = CNT_W'(w_delay);
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        // Running off the last entry never loops.
                        if (pc_q == c_LAST_PC) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            pc_d    = pc_q + AW'(1);
                            state_d = S_EXEC;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = 1'b1;
                    cont_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            sw_q     <= '0;
            run_q    <= 1'b1;
            cont_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pc_q     <= '0;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            run_q    <= run_d;
            cont_q   <= cont_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_en & busy_q;
        end
    end

    assign SW       = sw_q;
    assign Run      = run_q;
    assign Continue = cont_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pc       = pc_q;
    assign wr_err   = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_slc3_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_slc3_stim_sequencer
// Purpose  : Directed self-checking bench for slc3_stim_sequencer with
//            hand-computed cycle timings (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_slc3_stim_sequencer;

    localparam int SW_WIDTH    = 10;
    localparam int DEPTH       = 16;
    localparam int DELAY_WIDTH = 16;
    localparam int PULSE_LEN   = 2;
    localparam int AW          = 4;
    localparam int EW          = 2 + SW_WIDTH + DELAY_WIDTH;

    logic                Clk;
    logic                Reset;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [EW-1:0]       wr_data;
    logic                start;
    logic                abort;
    logic                loop_en;
    logic [SW_WIDTH-1:0] SW;
    logic                Run;
    logic                Continue;
    logic                busy;
    logic                done;
    logic [AW-1:0]       pc;
    logic                wr_err;

    int checks   = 0;
    int failures = 0;

    // Observations gathered by play().
    int lat, run_low, cont_low, nfall, werr_cnt, pc_back, busy_at_done;
    int falls [3];
    int sw1;
    int pc17, pc18, busy18;

    slc3_stim_sequencer #(
        .SW_WIDTH    (SW_WIDTH),
        .DEPTH       (DEPTH),
        .DELAY_WIDTH (DELAY_WIDTH),
        .PULSE_LEN   (PULSE_LEN)
    ) u_dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .abort    (abort),
        .loop_en  (loop_en),
        .SW       (SW),
        .Run      (Run),
        .Continue (Continue),
        .busy     (busy),
        .done     (done),
        .pc       (pc),
        .wr_err   (wr_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [9:0] v,
                                          input logic [15:0] d);
        return {op, v, d};
    endfunction

    task automatic wr(input int addr, input logic [EW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sw"},   32'(SW), 32'h0);
        chk({tag, "_run"},  32'(Run), 32'h1);
        chk({tag, "_cont"}, 32'(Continue), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pc"},   32'(pc), 32'h0);
        chk({tag, "_werr"}, 32'(wr_err), 32'h0);
    endtask

    // Pulse start, then watch until done or the cycle budget runs out.
    // n counts edges after the edge that sampled start.
    task automatic play(input int budget, input bit inject);
        int n;
        logic prev_cont;
        int prev_pc;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; run_low = 0; cont_low = 0; nfall = 0; werr_cnt = 0; pc_back = 0;
        sw1 = -1;
        for (int i = 0; i < 3; i++) falls[i] = -1;
        prev_cont = Continue;
        prev_pc = int'(pc);
        while (!done && n < budget) begin
            tick();
            n++;
            if (n == 1) sw1 = int'(SW);
            if (!Run) run_low++;
            if (!Continue) begin
                cont_low++;
                if (prev_cont) begin
                    if (nfall < 3) falls[nfall] = n;
                    nfall++;
                end
            end
            prev_cont = Continue;
            if (wr_err) werr_cnt++;
            if (int'(pc) < prev_pc) pc_back++;
            prev_pc = int'(pc);
            if (inject && n == 1) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = ent(2'b00, 10'h155, 16'd0);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        lat = n;
        busy_at_done = int'(busy);
    endtask

    initial begin
        Reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        chk_reset("rst");

        // SW load/hold: SET_SW 0x006 d=3, END
        wr(0, ent(2'b00, 10'h006, 16'd3));
        wr(1, ent(2'b11, 10'h000, 16'd0));
        play(100, 1'b0);
        chk("sw_after_exec", 32'(sw1), 32'h006);
        chk("sw_done_lat", 32'(lat), 32'd6);
        chk("sw_busy_fall", 32'(busy_at_done), 32'd0);
        tick(); tick();
        chk("sw_hold", 32'(SW), 32'h006);
        chk("sw_done_sticky", 32'(done), 32'h1);

        // Run pulse: PULSE_RUN d=0, END
        wr(0, ent(2'b01, 10'h000, 16'd0));
        wr(1, ent(2'b11, 10'h000, 16'd0));
        play(100, 1'b0);
        chk("run_low_cycles", 32'(run_low), 32'd2);
        chk("run_cont_high", 32'(cont_low), 32'd0);
        chk("run_done_lat", 32'(lat), 32'd5);
        chk("run_sw_unchanged", 32'(SW), 32'h006);

        // Sequence: SET_SW 0x3FF d=0, PULSE_CONT d=1 x3, END
        wr(0, ent(2'b00, 10'h3FF, 16'd0));
        wr(1, ent(2'b10, 10'h000, 16'd1));
        wr(2, ent(2'b10, 10'h000, 16'd1));
        wr(3, ent(2'b10, 10'h000, 16'd1));
        wr(4, ent(2'b11, 10'h000, 16'd0));
        play(100, 1'b0);
        chk("seq_nfall", 32'(nfall), 32'd3);
        chk("seq_fall0", 32'(falls[0]), 32'd3);
        chk("seq_fall1", 32'(falls[1]), 32'd8);
        chk("seq_fall2", 32'(falls[2]), 32'd13);
        chk("seq_cont_low", 32'(cont_low), 32'd6);
        chk("seq_run_low", 32'(run_low), 32'd0);
        chk("seq_lat", 32'(lat), 32'd18);
        chk("seq_pc_end", 32'(pc), 32'd4);
        chk("seq_pc_mono", 32'(pc_back), 32'd0);
        chk("seq_sw", 32'(SW), 32'h3FF);

        // Loop, then abort during the first looped Continue pulse.
        loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pc17 = -1; pc18 = -1; busy18 = -1;
        for (int n = 1; n <= 21; n++) begin
            tick();
            if (n == 17) pc17 = int'(pc);
            if (n == 18) begin
                pc18 = int'(pc);
                busy18 = int'(busy);
            end
        end
        chk("loop_pc_end", 32'(pc17), 32'd4);
        chk("loop_pc_wrap", 32'(pc18), 32'd0);
        chk("loop_busy", 32'(busy18), 32'd1);
        chk("loop_cont_low", 32'(Continue), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cont", 32'(Continue), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sw", 32'(SW), 32'h3FF);
        tick(); tick();
        chk("abort_idle", 32'(busy), 32'd0);

        // abort and start together: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_start_idle", 32'(busy), 32'd0);
        loop_en = 1'b0;

        // Write protection: write to entry 0 while busy, then replay.
        play(100, 1'b1);
        chk("wp_err_pulses", 32'(werr_cnt), 32'd1);
        chk("wp_lat", 32'(lat), 32'd18);
        tick();
        chk("wp_err_idle", 32'(wr_err), 32'd0);
        play(100, 1'b0);
        chk("wp_replay_sw", 32'(sw1), 32'h3FF);
        chk("wp_replay_nfall", 32'(nfall), 32'd3);

        // Implicit end: 16 SET_SW d=0 entries, loop_en set but no END.
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, ent(2'b00, 10'(16 + i), 16'd0));
        end
        loop_en = 1'b1;
        play(200, 1'b0);
        chk("impl_lat", 32'(lat), 32'd32);
        chk("impl_pc", 32'(pc), 32'd15);
        chk("impl_sw", 32'(SW), 32'h1F);
        chk("impl_busy", 32'(busy_at_done), 32'd0);
        loop_en = 1'b0;

        // Reset mid-WAIT.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 5; n++) tick();
        chk("rw_busy", 32'(busy), 32'd1);
        chk("rw_sw", 32'(SW), 32'h12);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_reset("rst_wait");

        // Reset mid-pulse releases Run at the same edge.
        wr(0, ent(2'b01, 10'h000, 16'd5));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rp_run_low", 32'(Run), 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rp_run_high", 32'(Run), 32'd1);
        chk("rp_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
